// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions (pipe_defs) for the ID-stage branch resolution unit:
// branch op codes, forwarding selects, load marker, FSM states and target arithmetic.
package branch_resolve_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BGEZ = 3'b011,
        OP_BGTZ = 3'b100,
        OP_BLEZ = 3'b101,
        OP_BLTZ = 3'b110,
        OP_RSVD = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WR  = 2'b11
    } fwd_sel_e;

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_e;

    function automatic logic is_branch(br_op_e op);
        return (op != OP_NONE) && (op != OP_RSVD);
    endfunction

    function automatic logic uses_b(br_op_e op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // imm16 counts words, so the byte offset is the sign-extended value shifted by two.
    function automatic logic [31:0] branch_target(logic [31:0] pc4, logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// ID-stage branch bus: decoded branch, operand sources and the stall/redirect response.
interface branch_resolve_if;

    logic        id_valid;
    logic [2:0]  id_br_op;
    logic [31:0] id_pc4;
    logic [15:0] id_imm16;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] ex_result;
    logic [31:0] mem_result;
    logic [31:0] wr_result;
    logic [1:0]  ex_memtoreg;
    logic [1:0]  mem_memtoreg;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ifid;

    modport master (
        output id_valid, id_br_op, id_pc4, id_imm16, id_rs_data, id_rt_data,
               fwd_a, fwd_b, ex_result, mem_result, wr_result,
               ex_memtoreg, mem_memtoreg,
        input  stall, redirect_valid, redirect_pc, flush_ifid
    );

    modport slave (
        input  id_valid, id_br_op, id_pc4, id_imm16, id_rs_data, id_rt_data,
               fwd_a, fwd_b, ex_result, mem_result, wr_result,
               ex_memtoreg, mem_memtoreg,
        output stall, redirect_valid, redirect_pc, flush_ifid
    );

endinterface

// File: rtl/branch_resolve_cmp.sv
// branch_cmp: combinational branch condition evaluation; the zero-compare ops are signed on A.
module branch_cmp
    import branch_resolve_pkg::*;
(
    input  br_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);

    logic a_zero;
    logic a_neg;

    assign a_zero = (a == '0);
    assign a_neg  = a[31];

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BGEZ: taken = !a_neg;
            OP_BGTZ: taken = !a_neg && !a_zero;
            OP_BLEZ: taken = a_neg || a_zero;
            OP_BLTZ: taken = a_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: operand forwarding mux, load-use stall FSM, registered redirect.
// Optional BRANCH_STATS_EN adds taken/not-taken/stall-cycle counters as extra outputs.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    branch_resolve_if.slave    bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]        stat_taken,
    output logic [31:0]        stat_not_taken,
    output logic [31:0]        stat_stall_cycles
`endif
);

    function automatic logic [31:0] operand_mux(fwd_sel_e sel, logic [31:0] rf,
                                                logic [31:0] ex, logic [31:0] mem,
                                                logic [31:0] wr);
        case (sel)
            FWD_RF:  return rf;
            FWD_EX:  return ex;
            FWD_MEM: return mem;
            default: return wr;
        endcase
    endfunction

    function automatic logic [1:0] hazard_need(fwd_sel_e sel, logic [1:0] ex_mtr,
                                               logic [1:0] mem_mtr);
        if (sel == FWD_EX && ex_mtr == MEMTOREG_LOAD) begin
            return 2'd2;
        end else if (sel == FWD_MEM && mem_mtr == MEMTOREG_LOAD) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    br_op_e      op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  need_a;
    logic [1:0]  need_b;
    logic [1:0]  need;
    logic        br_present;
    logic        taken;
    logic        resolve;
    logic        stall_raw;

    br_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        flush_ifid_q, flush_ifid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    assign op   = br_op_e'(bus.id_br_op);
    assign op_a = operand_mux(fwd_sel_e'(bus.fwd_a), bus.id_rs_data, bus.ex_result,
                              bus.mem_result, bus.wr_result);
    assign op_b = operand_mux(fwd_sel_e'(bus.fwd_b), bus.id_rt_data, bus.ex_result,
                              bus.mem_result, bus.wr_result);

    assign need_a = hazard_need(fwd_sel_e'(bus.fwd_a), bus.ex_memtoreg, bus.mem_memtoreg);
    assign need_b = uses_b(op) ? hazard_need(fwd_sel_e'(bus.fwd_b), bus.ex_memtoreg,
                                             bus.mem_memtoreg)
                               : 2'd0;
    assign need   = (need_a > need_b) ? need_a : need_b;

    // A branch in the delay slot of a taken branch is ignored entirely.
    assign br_present = bus.id_valid && is_branch(op) && !redirect_valid_q;

    branch_cmp u_cmp (
        .op    (op),
        .a     (op_a),
        .b     (op_b),
        .taken (taken)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        resolve   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_present) begin
                    if (need != 2'd0) begin
                        stall_raw = 1'b1;
                        state_d   = ST_WAIT;
                        cnt_d     = need - 2'd1;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.id_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 2'd0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - 2'd1;
                end else begin
                    resolve = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        redirect_valid_d = resolve && taken;
        flush_ifid_d     = resolve && taken;
        redirect_pc_d    = redirect_pc_q;
        if (resolve && taken) begin
            redirect_pc_d = branch_target(bus.id_pc4, bus.id_imm16);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            flush_ifid_q     <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            flush_ifid_q     <= flush_ifid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Reset gates stall so an in-flight hazard releases the pipeline immediately.
    assign bus.stall          = stall_raw && rst_n;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.flush_ifid     = flush_ifid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] not_taken_cnt_q, not_taken_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        if (resolve && taken) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
        if (resolve && !taken) begin
            not_taken_cnt_d = not_taken_cnt_q + 32'd1;
        end
        if (stall_raw) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
            stall_cnt_q     <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign stat_taken        = taken_cnt_q;
    assign stat_not_taken    = not_taken_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: stimulus pushes expected redirect targets, a negedge
// monitor pops one per redirect pulse; stall is checked directly after each input change.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_resolve_if bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
    logic [31:0] stat_stall_cycles;
`endif

    branch_resolve dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken        (stat_taken),
        .stat_not_taken    (stat_not_taken),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.redirect_valid !== 1'b0 || bus.flush_ifid !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_redirect: got valid=%b flush=%b pc=0x%08h, expected no pulse",
                         bus.redirect_valid, bus.flush_ifid, bus.redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check32("redirect_pc", bus.redirect_pc, e);
                check32("redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
                check32("flush_ifid", {31'b0, bus.flush_ifid}, 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid     = 1'b0;
        bus.id_br_op     = 3'b000;
        bus.id_pc4       = '0;
        bus.id_imm16     = '0;
        bus.id_rs_data   = '0;
        bus.id_rt_data   = '0;
        bus.fwd_a        = 2'b00;
        bus.fwd_b        = 2'b00;
        bus.ex_result    = '0;
        bus.mem_result   = '0;
        bus.wr_result    = '0;
        bus.ex_memtoreg  = 2'b00;
        bus.mem_memtoreg = 2'b00;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] pc4, input logic [15:0] imm,
                           input logic [31:0] rs, input logic [31:0] rt);
        idle_inputs();
        bus.id_valid   = 1'b1;
        bus.id_br_op   = op;
        bus.id_pc4     = pc4;
        bus.id_imm16   = imm;
        bus.id_rs_data = rs;
        bus.id_rt_data = rt;
    endtask

    task automatic drain();
        cyc();
        idle_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_stall", {31'b0, bus.stall}, 32'd0);
        check32("reset_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        check32("reset_flush_ifid", {31'b0, bus.flush_ifid}, 32'd0);
        check32("reset_redirect_pc", bus.redirect_pc, 32'h0);
        rst_n = 1'b1;
        cyc();

        // BEQ taken, no hazard
        present(3'b001, 32'h0040_0004, 16'h0003, 32'd5, 32'd5);
        #1 check32("beq_stall", {31'b0, bus.stall}, 32'd0);
        exp_q.push_back(32'h0040_0010);
        drain();

        // BNE taken with negative offset, then not taken
        present(3'b010, 32'h0040_0004, 16'hFFFF, 32'd1, 32'd2);
        #1 check32("bne_stall", {31'b0, bus.stall}, 32'd0);
        exp_q.push_back(32'h0040_0000);
        drain();
        present(3'b010, 32'h0040_0004, 16'hFFFF, 32'd7, 32'd7);
        drain();

        // BLTZ via MEM forward (not a load), taken then not taken
        present(3'b110, 32'h0040_0100, 16'h0010, 32'h0, 32'h0);
        bus.fwd_a      = 2'b10;
        bus.mem_result = 32'h8000_0000;
        #1 check32("bltz_stall", {31'b0, bus.stall}, 32'd0);
        exp_q.push_back(32'h0040_0140);
        drain();
        present(3'b110, 32'h0040_0100, 16'h0010, 32'h8000_0000, 32'h0);
        bus.fwd_a      = 2'b10;
        bus.mem_result = 32'h0;
        drain();

        // BEQ with operand A loading in EX: two stall cycles, resolve on the third
        present(3'b001, 32'h0040_1000, 16'h0008, 32'hDEAD, 32'h1234);
        bus.fwd_a       = 2'b01;
        bus.ex_memtoreg = 2'b01;
        bus.ex_result   = 32'h9999;
        #1 check32("ex_load_stall_c0", {31'b0, bus.stall}, 32'd1);
        cyc();
        #1 check32("ex_load_stall_c1", {31'b0, bus.stall}, 32'd1);
        cyc();
        bus.fwd_a       = 2'b11;
        bus.wr_result   = 32'h1234;
        bus.ex_memtoreg = 2'b00;
        #1 check32("ex_load_resolve_stall", {31'b0, bus.stall}, 32'd0);
        exp_q.push_back(32'h0040_1020);
        drain();
`ifdef BRANCH_STATS_EN
        check32("stat_stall_cycles", stat_stall_cycles, 32'd2);
        check32("stat_taken", stat_taken, 32'd4);
        check32("stat_not_taken", stat_not_taken, 32'd2);
`endif

        // MEM load hazard, reset asserted during WAIT
        present(3'b001, 32'h0040_2000, 16'h0001, 32'd0, 32'd0);
        bus.fwd_b        = 2'b10;
        bus.mem_result   = 32'd0;
        bus.mem_memtoreg = 2'b01;
        #1 check32("mem_load_stall", {31'b0, bus.stall}, 32'd1);
        cyc();
        rst_n = 1'b0;
        #1 check32("reset_mid_wait_stall", {31'b0, bus.stall}, 32'd0);
        check32("reset_mid_wait_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        cyc();
        idle_inputs();
        rst_n = 1'b1;
        cyc();
        cyc();
        cyc();
`ifdef BRANCH_STATS_EN
        check32("stat_taken_after_reset", stat_taken, 32'd0);
`endif

        // EX load hazard, id_valid dropped while waiting
        present(3'b001, 32'h0040_3000, 16'h0001, 32'd4, 32'd4);
        bus.fwd_a       = 2'b01;
        bus.ex_memtoreg = 2'b01;
        bus.ex_result   = 32'd4;
        #1 check32("abort_stall_c0", {31'b0, bus.stall}, 32'd1);
        cyc();
        bus.id_valid = 1'b0;
        #1 check32("abort_stall", {31'b0, bus.stall}, 32'd0);
        drain();

        // Taken branch, then a hazardous branch in its delay slot is ignored
        present(3'b001, 32'h0040_4000, 16'h0002, 32'd1, 32'd1);
        exp_q.push_back(32'h0040_4008);
        cyc();
        present(3'b010, 32'h0040_5000, 16'h0040, 32'd1, 32'd2);
        bus.fwd_a       = 2'b01;
        bus.ex_memtoreg = 2'b01;
        #1 check32("delay_slot_stall", {31'b0, bus.stall}, 32'd0);
        drain();
        cyc();

        check32("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

ID-stage branch resolution unit for the 5-stage MIPS pipeline; consumes the per-operand forwarding selects produced by the branch forwarding unit. It muxes rs/rt from the register file or from the EX/MEM/WR results and evaluates the branch condition. It stalls IF/ID when a load has not yet produced a needed operand, then issues a registered PC redirect plus an IF/ID flush.

## Interface
- Parameters: none (widths fixed by the 32-bit datapath).
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_br_op  in  3  000 none, 001 BEQ, 010 BNE, 011 BGEZ, 100 BGTZ, 101 BLEZ, 110 BLTZ, 111 reserved (treated as none)
- id_pc4  in  32  PC+4 of the branch
- id_imm16  in  16  branch offset in words
- id_rs_data, id_rt_data  in  32  register-file read data
- fwd_a, fwd_b  in  2  operand source: 00 regfile, 01 EX, 10 MEM, 11 WR
- ex_result, mem_result, wr_result  in  32  stage results
- ex_memtoreg, mem_memtoreg  in  2  value 01 = stage holds a load
- stall  out  1  hold PC and IF/ID
- redirect_valid  out  1  registered; load PC with redirect_pc
- redirect_pc  out  32  registered branch target
- flush_ifid  out  1  registered; clear IF/ID to a bubble

## Operation
- Operand A = mux(fwd_a); operand B = mux(fwd_b). B is used only by BEQ/BNE.
- Hazard need: a used operand with select 01 and ex_memtoreg==01 → 2 cycles; select 10 and mem_memtoreg==01 → 1 cycle; the maximum over both operands is taken.
- FSM IDLE/WAIT with 2-bit count cnt:
  - IDLE, branch present (id_valid, op 001..110, redirect_valid low), need>0 → stall=1, go WAIT, cnt=need-1.
  - IDLE, branch present, need==0 → resolve this cycle.
  - WAIT, cnt!=0 → stall=1, cnt decrements.
  - WAIT, cnt==0 → stall=0, resolve with the current selects, return to IDLE.
  - WAIT with id_valid low → abort to IDLE, stall=0, no redirect.
- Resolve: compare per op (signed for BGEZ/BGTZ/BLEZ/BLTZ). If taken, the next edge sets redirect_valid=1, flush_ifid=1, and redirect_pc = id_pc4 + (sign-extended imm16 << 2), mod 2^32. Not-taken: no pulse.
- The instruction at id_pc4 is the delay slot and executes. flush_ifid discards the fetch after it.
- A branch seen in ID while redirect_valid=1 (a branch in the delay slot) is ignored: no stall, no redirect.

## Timing
- Reset: stall=0, redirect_valid=0, flush_ifid=0, redirect_pc=0, state IDLE, cnt=0, statistics 0. Reset asserted mid-WAIT returns to IDLE immediately.
- stall is combinational from state and current inputs.
- redirect_valid/flush_ifid are one-cycle pulses, one cycle after the resolve cycle.
- Load in EX: 2 stall cycles, resolves in the 3rd cycle, redirect in the 4th. Load in MEM: 1 stall cycle.

## Configuration
- BRANCH_STATS_EN defined: adds outputs stat_taken, stat_not_taken and stat_stall_cycles (32 bits each).
  - stat_taken / stat_not_taken increment on each resolve; stat_stall_cycles increments on each cycle with stall=1.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

## Structure
- Shared package/header pipe_defs holds:
  - branch op codes
  - forwarding select codes (00/01/10/11)
  - MEMTOREG_LOAD = 2'b01
  - FSM state encodings
- Sub-module branch_cmp: purely combinational; inputs op, A, B; output taken.

## Test plan
- BEQ, rs=rt=5 (fwd 00), pc4=0x00400004, imm=0x0003 → no stall; next cycle redirect_valid=1, flush_ifid=1, redirect_pc=0x00400010.
- BNE, A=1, B=2, imm=0xFFFF, pc4=0x00400004 → redirect_pc=0x00400000. With A=B → no pulse.
- BLTZ with A=0x80000000 via fwd 10 (mem_memtoreg=00) → taken. With A=0 → not taken.
- BEQ, fwd_a=01, ex_memtoreg=01 → stall=1 for 2 cycles. The bench then sets fwd_a=11 with wr_result equal to B → redirect after resolve. Without BRANCH_STATS_EN, stat_stall_cycles is absent; with it, stat_stall_cycles=2.
- Load hazard in MEM, then rst_n low during WAIT → stall=0 at once, no redirect after release. Separately, id_valid dropped in WAIT → abort.
- Taken branch followed by a branch in the delay slot while redirect_valid=1 → the second branch is ignored, exactly one redirect pulse.
